uart_rx: RTL

UART serial receiver that pairs with the team's uart_tx block. It uses the same frame format and baud parameters: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), idle high.
- Samples an asynchronous rx_in line and validates the start bit.
- Samples each bit at mid-period and checks the stop bit.
- Presents the received byte with a one-cycle valid strobe.
- Sits at the chip serial input, feeding a host-side consumer.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_rx_if.sv | 22 ++
 rtl/uart_sync2.sv | 24 ++
 rtl/uart_rx.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and baud helper.
// Used by both uart_rx and uart_tx.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } uart_state_t;

  localparam int unsigned DATA_BITS   = 8;
  localparam logic        IDLE_LEVEL  = 1'b1;
  localparam logic        START_LEVEL = 1'b0;

  function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
    return clk_freq / baud_rate;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side serial/byte signal bundle. rx_parity_err exists only when
// UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic       rx_in;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_busy;
`ifdef UART_RX_PARITY_EN
  logic       rx_parity_err;

  modport master (input rx_in, output rx_data, output rx_valid,
                  output rx_frame_err, output rx_busy, output rx_parity_err);
  modport slave  (output rx_in, input rx_data, input rx_valid,
                  input rx_frame_err, input rx_busy, input rx_parity_err);
`else
  modport master (input rx_in, output rx_data, output rx_valid,
                  output rx_frame_err, output rx_busy);
  modport slave  (output rx_in, input rx_data, input rx_valid,
                  input rx_frame_err, input rx_busy);
`endif
endinterface

// File: rtl/uart_sync2.sv
// Two-flop synchroniser for a single asynchronous input; both flops reset
// to RST_VAL so the output is quiet at the idle level after reset.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 1 start, 8 data LSB first, 1 stop, idle high.
// Define UART_RX_PARITY_EN to add an even-parity bit and rx_parity_err.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50000000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic      clk,
  input  logic      rst_n,
  uart_rx_if.master rx_bus
);

  localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0] CNT_BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF_END = CNT_W'(HALF_BIT - 1);
  localparam logic [2:0]       LAST_BIT     = 3'(DATA_BITS - 1);

  uart_state_t      state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             rx_s;
`ifdef UART_RX_PARITY_EN
  logic             par_bit;
`endif

  uart_sync2 #(.RST_VAL(IDLE_LEVEL)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx_bus.rx_in),
    .q     (rx_s)
  );

  always_comb begin
    rx_bus.rx_busy = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state               <= IDLE;
      cnt                 <= '0;
      bit_idx             <= '0;
      shift               <= '0;
      rx_bus.rx_data      <= '0;
      rx_bus.rx_valid     <= 1'b0;
      rx_bus.rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit              <= 1'b0;
      rx_bus.rx_parity_err <= 1'b0;
`endif
    end else begin
      rx_bus.rx_valid     <= 1'b0;
      rx_bus.rx_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx_bus.rx_parity_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          cnt <= '0;
          if (rx_s == START_LEVEL) state <= START;
        end

        // Half a bit here aligns every later sample with a bit centre.
        START: begin
          if (cnt == CNT_HALF_END) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= (rx_s == START_LEVEL) ? DATA : IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        DATA: begin
          if (cnt == CNT_BIT_END) begin
            cnt            <= '0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 1'b1;
            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (cnt == CNT_BIT_END) begin
            cnt     <= '0;
            par_bit <= rx_s;
            state   <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif

        // Leaving at mid-stop-bit lets a following start edge be seen in IDLE.
        STOP: begin
          if (cnt == CNT_BIT_END) begin
            cnt <= '0;
            if (rx_s == IDLE_LEVEL) begin
              state <= IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bit != ^shift) begin
                rx_bus.rx_parity_err <= 1'b1;
              end else begin
                rx_bus.rx_data  <= shift;
                rx_bus.rx_valid <= 1'b1;
              end
`else
              rx_bus.rx_data  <= shift;
              rx_bus.rx_valid <= 1'b1;
`endif
            end else begin
              rx_bus.rx_frame_err <= 1'b1;
              state               <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // A held-low line (break) must not be taken as further start bits.
        WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s == IDLE_LEVEL) state <= IDLE;
        end

        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
